imo_seq_engine: RTL

Programmable in-memory-operation (IMO) request sequencer. It sits between a host/debug front end and the memory controller's IMO request/response port. It holds a small loadable program of IMO instructions (control-register writes, RLRD, COPY, RNG buffer size/read) and issues them in order with a valid/ack handshake. Entries flagged for a response are held until the controller returns `imo_resp_valid`, and that data is captured. The program repeats a configurable number of times, with per-handshake timeout detection and abort.

---
 rtl/imo_seq_pkg.sv | 27 ++
 rtl/imo_seq_engine_prog_mem.sv | 35 +++
 rtl/imo_seq_engine.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/imo_seq_pkg.sv
// Shared definitions for the IMO request sequencer: default sizes, derived
// widths and the engine state encoding.
package imo_seq_pkg;

    localparam int DEPTH_DEF  = 16;
    localparam int INST_W_DEF = 128;
    localparam int RESP_W_DEF = 512;
    localparam int LOOP_W_DEF = 8;
    localparam int TMO_W_DEF  = 12;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);
    localparam int LEN_W_DEF = PTR_W_DEF + 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_CAL  = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERROR     = 3'd5
    } state_e;

endpackage

// File: rtl/imo_seq_engine_prog_mem.sv
// Program store: each slot holds one IMO instruction plus its wait-for-response
// flag. Synchronous write, asynchronous read, cleared by reset.
module imo_seq_prog_mem
    import imo_seq_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int PTR_W  = ptr_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [INST_W-1:0] winst_i,
    input  logic              wwait_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [INST_W-1:0] rinst_o,
    output logic              rwait_o
);

    logic [INST_W:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= {wwait_i, winst_i};
        end
    end

    assign {rwait_o, rinst_o} = mem_q[raddr_i];

endmodule

// File: rtl/imo_seq_engine.sv
// IMO request sequencer: replays a loaded program over a valid/ack request
// port, optionally waiting for responses, with looping, timeout and abort.
module imo_seq_engine
    import imo_seq_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int RESP_W = RESP_W_DEF,
    parameter int LOOP_W = LOOP_W_DEF,
    parameter int TMO_W  = TMO_W_DEF,
    localparam int PTR_W = ptr_w(DEPTH),
    localparam int LEN_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_calib_complete,
    input  logic              prog_we,
    input  logic [PTR_W-1:0]  prog_addr,
    input  logic [INST_W-1:0] prog_inst,
    input  logic              prog_wait_resp,
    input  logic [LEN_W-1:0]  prog_len,
    input  logic [LOOP_W-1:0] loop_cnt,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [PTR_W-1:0]  err_slot,
    output logic              err_in_resp,
    output logic              imo_req_valid,
    output logic [INST_W-1:0] imo_req_inst,
    input  logic              imo_req_ack,
    input  logic [RESP_W-1:0] imo_resp_data,
    input  logic              imo_resp_valid,
    output logic [RESP_W-1:0] resp_last,
    output logic [15:0]       resp_cnt,
    output logic [2:0]        dbg_state
);

    // Handshake: a request transfers on any cycle where imo_req_valid and
    // imo_req_ack are both high; valid and inst stay stable until then.
    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [LOOP_W-1:0] iter_q, iter_d, loop_q, loop_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;
    logic              done_q, done_d, error_q, error_d;
    logic [PTR_W-1:0]  err_slot_q, err_slot_d;
    logic              err_in_resp_q, err_in_resp_d;
    logic [RESP_W-1:0] resp_last_q, resp_last_d;
    logic [15:0]       resp_cnt_q, resp_cnt_d;
    logic [INST_W-1:0] cur_inst;
    logic              cur_wait, capture, advance, timeout;

    imo_seq_prog_mem #(.DEPTH(DEPTH), .INST_W(INST_W), .PTR_W(PTR_W)) u_prog_mem (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .we_i    (prog_we & ~busy),
        .waddr_i (prog_addr),
        .winst_i (prog_inst),
        .wwait_i (prog_wait_resp),
        .raddr_i (ptr_q),
        .rinst_o (cur_inst),
        .rwait_o (cur_wait)
    );

    assign tmo_inc = tmo_q + 1'b1;
    assign timeout = (tmo_inc == '1);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        iter_d        = iter_q;
        loop_d        = loop_q;
        len_d         = len_q;
        tmo_d         = tmo_q;
        done_d        = done_q;
        error_d       = error_q;
        err_slot_d    = err_slot_q;
        err_in_resp_d = err_in_resp_q;
        resp_last_d   = resp_last_q;
        resp_cnt_d    = resp_cnt_q;
        capture       = 1'b0;
        advance       = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        done_d     = 1'b0;
                        error_d    = 1'b0;
                        resp_cnt_d = '0;
                        len_d      = prog_len;
                        loop_d     = loop_cnt;
                        ptr_d      = '0;
                        iter_d     = '0;
                        tmo_d      = '0;
                        if (prog_len == '0) begin
                            // An empty program completes immediately.
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else if (init_calib_complete) begin
                            state_d = ST_ISSUE;
                        end else begin
                            state_d = ST_WAIT_CAL;
                        end
                    end
                end
                ST_WAIT_CAL: begin
                    if (init_calib_complete) begin
                        state_d = ST_ISSUE;
                        tmo_d   = '0;
                    end
                end
                ST_ISSUE: begin
                    if (imo_req_ack) begin
                        if (cur_wait && !imo_resp_valid) begin
                            state_d = ST_WAIT_RESP;
                            tmo_d   = '0;
                        end else begin
                            capture = cur_wait;
                            advance = 1'b1;
                        end
                    end else if (timeout) begin
                        state_d       = ST_ERROR;
                        error_d       = 1'b1;
                        err_slot_d    = ptr_q;
                        err_in_resp_d = 1'b0;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
                ST_WAIT_RESP: begin
                    if (imo_resp_valid) begin
                        capture = 1'b1;
                        advance = 1'b1;
                    end else if (timeout) begin
                        state_d       = ST_ERROR;
                        error_d       = 1'b1;
                        err_slot_d    = ptr_q;
                        err_in_resp_d = 1'b1;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (capture) begin
                resp_last_d = imo_resp_data;
                if (resp_cnt_q != 16'hFFFF) begin
                    resp_cnt_d = resp_cnt_q + 16'd1;
                end
            end

            // Moving to the next slot or pass keeps valid high without a bubble.
            if (advance) begin
                tmo_d = '0;
                if (({1'b0, ptr_q} + LEN_W'(1)) < len_q) begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = ST_ISSUE;
                end else if (iter_q < loop_q) begin
                    ptr_d   = '0;
                    iter_d  = iter_q + 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            iter_q        <= '0;
            loop_q        <= '0;
            len_q         <= '0;
            tmo_q         <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_slot_q    <= '0;
            err_in_resp_q <= 1'b0;
            resp_last_q   <= '0;
            resp_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            iter_q        <= iter_d;
            loop_q        <= loop_d;
            len_q         <= len_d;
            tmo_q         <= tmo_d;
            done_q        <= done_d;
            error_q       <= error_d;
            err_slot_q    <= err_slot_d;
            err_in_resp_q <= err_in_resp_d;
            resp_last_q   <= resp_last_d;
            resp_cnt_q    <= resp_cnt_d;
        end
    end

    assign busy          = (state_q == ST_WAIT_CAL) || (state_q == ST_ISSUE) ||
                           (state_q == ST_WAIT_RESP);
    assign imo_req_valid = (state_q == ST_ISSUE);
    assign imo_req_inst  = imo_req_valid ? cur_inst : '0;
    assign done          = done_q;
    assign error         = error_q;
    assign err_slot      = err_slot_q;
    assign err_in_resp   = err_in_resp_q;
    assign resp_last     = resp_last_q;
    assign resp_cnt      = resp_cnt_q;
    assign dbg_state     = state_q;

endmodule
